// File: rtl/cv32e41s_pmp_check_sched_pkg.sv
// Types shared by the PMP check scheduler and its round-robin arbiter.
package cv32e41s_pmp_check_sched_pkg;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } privlvl_t;

  typedef enum logic [1:0] {
    PMP_ACC_EXEC  = 2'b00,
    PMP_ACC_WRITE = 2'b01,
    PMP_ACC_READ  = 2'b10
  } pmp_req_e;

  typedef enum logic [1:0] {IDLE, CHK_LO, CHK_HI, RSP} pmp_sched_state_e;

  typedef enum logic {PMP_RQ_IFU, PMP_RQ_LSU} pmp_requester_e;

  typedef struct packed {
    logic [33:0]    addr;
    pmp_req_e       acc_type;
    logic [1:0]     size;
    logic           debug_region;
    privlvl_t       priv_lvl;
    pmp_requester_e requester;
  } pmp_sched_req_t;

  localparam pmp_sched_req_t PMP_SCHED_REQ_RESET = '{
    addr:         '0,
    acc_type:     PMP_ACC_READ,
    size:         2'd0,
    debug_region: 1'b0,
    priv_lvl:     PRIV_LVL_M,
    requester:    PMP_RQ_IFU
  };

  // Size encoding 3 is illegal and behaves as a word.
  function automatic logic [2:0] size_bytes(logic [1:0] size);
    unique case (size)
      2'd0:    size_bytes = 3'd1;
      2'd1:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/cv32e41s_pmp_rr_arb2.sv
// Two-input round-robin arbiter between IFU and LSU; a tie goes to the requester not granted last.
module cv32e41s_pmp_rr_arb2
  import cv32e41s_pmp_check_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_ifu_i,
  input  logic req_lsu_i,
  input  logic accept_i,
  output logic gnt_ifu_o,
  output logic gnt_lsu_o
);

  pmp_requester_e last_grant_q;

  always_comb begin
    gnt_ifu_o = 1'b0;
    gnt_lsu_o = 1'b0;
    if (req_ifu_i && req_lsu_i) begin
      gnt_lsu_o = (last_grant_q == PMP_RQ_IFU);
      gnt_ifu_o = !gnt_lsu_o;
    end else begin
      gnt_ifu_o = req_ifu_i;
      gnt_lsu_o = req_lsu_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= PMP_RQ_IFU;
    end else if (accept_i) begin
      last_grant_q <= gnt_lsu_o ? PMP_RQ_LSU : PMP_RQ_IFU;
    end
  end

endmodule

// File: rtl/cv32e41s_pmp_check_sched.sv
// Time-shares one PMP checker between IFU and LSU, splitting word-crossing LSU accesses in two.
// Optional first-fault capture is enabled by defining CV32E41S_PMP_FAULT_CAPTURE_EN.
module cv32e41s_pmp_check_sched
  import cv32e41s_pmp_check_sched_pkg::*;
#(
  parameter int unsigned PMP_NUM_REGIONS = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  privlvl_t    priv_lvl_i,
  input  logic        ifu_req_valid_i,
  output logic        ifu_req_ready_o,
  input  logic [33:0] ifu_req_addr_i,
  input  logic        ifu_req_debug_region_i,
  input  logic        lsu_req_valid_i,
  output logic        lsu_req_ready_o,
  input  logic [33:0] lsu_req_addr_i,
  input  logic        lsu_req_we_i,
  input  logic [1:0]  lsu_req_size_i,
  input  logic        lsu_req_debug_region_i,
  output logic [33:0] pmp_req_addr_o,
  output pmp_req_e    pmp_req_type_o,
  output logic        pmp_req_debug_region_o,
  output privlvl_t    pmp_priv_lvl_o,
  input  logic        pmp_req_err_i,
  output logic        ifu_rsp_valid_o,
  output logic        ifu_rsp_err_o,
  output logic        lsu_rsp_valid_o,
  output logic        lsu_rsp_err_o,
  output logic        fault_valid_o,
  output logic [33:0] fault_addr_o,
  input  logic        fault_clr_i
);

  pmp_sched_state_e state_q, state_d;
  pmp_sched_req_t   req_q, req_d;
  logic             err_lo_q, err_hi_q;
  logic             gnt_ifu, gnt_lsu, accept_window, accept_ifu, accept_lsu, accept, split;
  logic [33:0]      hi_addr;

  // Region count only matters inside the checker; the scheduling is identical for any value.
  logic unused_sig;
  assign unused_sig = ^{ifu_req_addr_i[1:0], (PMP_NUM_REGIONS != 0)};

  cv32e41s_pmp_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_ifu_i (ifu_req_valid_i),
    .req_lsu_i (lsu_req_valid_i),
    .accept_i  (accept),
    .gnt_ifu_o (gnt_ifu),
    .gnt_lsu_o (gnt_lsu)
  );

  assign accept_window   = rst_n && ((state_q == IDLE) || (state_q == RSP));
  assign ifu_req_ready_o = accept_window && gnt_ifu;
  assign lsu_req_ready_o = accept_window && gnt_lsu;
  assign accept_ifu      = ifu_req_valid_i && ifu_req_ready_o;
  assign accept_lsu      = lsu_req_valid_i && lsu_req_ready_o;
  assign accept          = accept_ifu || accept_lsu;

  assign split   = (req_q.requester == PMP_RQ_LSU) &&
                   (({1'b0, req_q.addr[1:0]} + size_bytes(req_q.size)) > 3'd4);
  assign hi_addr = {req_q.addr[33:2] + 32'd1, 2'b00};

  always_comb begin
    req_d = req_q;
    if (accept_lsu) begin
      req_d.addr         = lsu_req_addr_i;
      req_d.acc_type     = lsu_req_we_i ? PMP_ACC_WRITE : PMP_ACC_READ;
      req_d.size         = lsu_req_size_i;
      req_d.debug_region = lsu_req_debug_region_i;
      req_d.priv_lvl     = priv_lvl_i;
      req_d.requester    = PMP_RQ_LSU;
    end else if (accept_ifu) begin
      req_d.addr         = {ifu_req_addr_i[33:2], 2'b00};
      req_d.acc_type     = PMP_ACC_EXEC;
      req_d.size         = 2'd2;
      req_d.debug_region = ifu_req_debug_region_i;
      req_d.priv_lvl     = priv_lvl_i;
      req_d.requester    = PMP_RQ_IFU;
    end
  end

  always_comb begin
    state_d                = state_q;
    pmp_req_addr_o         = '0;
    pmp_req_type_o         = PMP_ACC_READ;
    pmp_req_debug_region_o = 1'b0;
    pmp_priv_lvl_o         = PRIV_LVL_M;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = CHK_LO;
      end
      CHK_LO: begin
        pmp_req_addr_o         = req_q.addr;
        pmp_req_type_o         = req_q.acc_type;
        pmp_req_debug_region_o = req_q.debug_region;
        pmp_priv_lvl_o         = req_q.priv_lvl;
        state_d                = split ? CHK_HI : RSP;
      end
      CHK_HI: begin
        pmp_req_addr_o         = hi_addr;
        pmp_req_type_o         = req_q.acc_type;
        pmp_req_debug_region_o = req_q.debug_region;
        pmp_priv_lvl_o         = req_q.priv_lvl;
        state_d                = RSP;
      end
      RSP: begin
        state_d = accept ? CHK_LO : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= PMP_SCHED_REQ_RESET;
      err_lo_q <= 1'b0;
      err_hi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      // err_hi must be cleared so an unsplit request does not inherit an old hi fault.
      if (accept) begin
        err_lo_q <= 1'b0;
        err_hi_q <= 1'b0;
      end else if (state_q == CHK_LO) begin
        err_lo_q <= pmp_req_err_i;
      end else if (state_q == CHK_HI) begin
        err_hi_q <= pmp_req_err_i;
      end
    end
  end

  assign ifu_rsp_valid_o = (state_q == RSP) && (req_q.requester == PMP_RQ_IFU);
  assign lsu_rsp_valid_o = (state_q == RSP) && (req_q.requester == PMP_RQ_LSU);
  assign ifu_rsp_err_o   = ifu_rsp_valid_o && (err_lo_q || err_hi_q);
  assign lsu_rsp_err_o   = lsu_rsp_valid_o && (err_lo_q || err_hi_q);

`ifdef CV32E41S_PMP_FAULT_CAPTURE_EN
  logic        fault_valid_q;
  logic [33:0] fault_addr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
    end else if (fault_clr_i) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
    end else if (!fault_valid_q && pmp_req_err_i &&
                 ((state_q == CHK_LO) || (state_q == CHK_HI))) begin
      fault_valid_q <= 1'b1;
      fault_addr_q  <= pmp_req_addr_o;
    end
  end

  assign fault_valid_o = fault_valid_q;
  assign fault_addr_o  = fault_addr_q;
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr_i;
  assign fault_valid_o    = 1'b0;
  assign fault_addr_o     = '0;
`endif

endmodule

// File: tb/tb_cv32e41s_pmp_check_sched.sv
// Self-checking bench: directed scenarios plus a randomized run against a transaction-level model.
module tb_cv32e41s_pmp_check_sched;
  import cv32e41s_pmp_check_sched_pkg::*;

  logic        clk;
  logic        rst_n;
  privlvl_t    priv_lvl_i;
  logic        ifu_req_valid_i, ifu_req_ready_o, ifu_req_debug_region_i;
  logic [33:0] ifu_req_addr_i;
  logic        lsu_req_valid_i, lsu_req_ready_o, lsu_req_we_i, lsu_req_debug_region_i;
  logic [33:0] lsu_req_addr_i;
  logic [1:0]  lsu_req_size_i;
  logic [33:0] pmp_req_addr_o;
  pmp_req_e    pmp_req_type_o;
  logic        pmp_req_debug_region_o;
  privlvl_t    pmp_priv_lvl_o;
  logic        pmp_req_err_i;
  logic        ifu_rsp_valid_o, ifu_rsp_err_o, lsu_rsp_valid_o, lsu_rsp_err_o;
  logic        fault_valid_o;
  logic [33:0] fault_addr_o;
  logic        fault_clr_i;

  int total = 0;
  int bad   = 0;

  // Stand-in checker: faults on up to two exact addresses, or on a bit pattern.
  logic [33:0] bad_a, bad_b;
  logic        bad_a_en, bad_b_en, pat_en;
  assign pmp_req_err_i = (bad_a_en && (pmp_req_addr_o == bad_a)) ||
                         (bad_b_en && (pmp_req_addr_o == bad_b)) ||
                         (pat_en && (pmp_req_addr_o[4] ^ pmp_req_addr_o[7]));

  cv32e41s_pmp_check_sched #(.PMP_NUM_REGIONS(4)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .priv_lvl_i             (priv_lvl_i),
    .ifu_req_valid_i        (ifu_req_valid_i),
    .ifu_req_ready_o        (ifu_req_ready_o),
    .ifu_req_addr_i         (ifu_req_addr_i),
    .ifu_req_debug_region_i (ifu_req_debug_region_i),
    .lsu_req_valid_i        (lsu_req_valid_i),
    .lsu_req_ready_o        (lsu_req_ready_o),
    .lsu_req_addr_i         (lsu_req_addr_i),
    .lsu_req_we_i           (lsu_req_we_i),
    .lsu_req_size_i         (lsu_req_size_i),
    .lsu_req_debug_region_i (lsu_req_debug_region_i),
    .pmp_req_addr_o         (pmp_req_addr_o),
    .pmp_req_type_o         (pmp_req_type_o),
    .pmp_req_debug_region_o (pmp_req_debug_region_o),
    .pmp_priv_lvl_o         (pmp_priv_lvl_o),
    .pmp_req_err_i          (pmp_req_err_i),
    .ifu_rsp_valid_o        (ifu_rsp_valid_o),
    .ifu_rsp_err_o          (ifu_rsp_err_o),
    .lsu_rsp_valid_o        (lsu_rsp_valid_o),
    .lsu_rsp_err_o          (lsu_rsp_err_o),
    .fault_valid_o          (fault_valid_o),
    .fault_addr_o           (fault_addr_o),
    .fault_clr_i            (fault_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    priv_lvl_i = PRIV_LVL_M;
    ifu_req_valid_i = 1'b0; ifu_req_addr_i = '0; ifu_req_debug_region_i = 1'b0;
    lsu_req_valid_i = 1'b0; lsu_req_addr_i = '0; lsu_req_we_i = 1'b0;
    lsu_req_size_i = 2'd0; lsu_req_debug_region_i = 1'b0;
    fault_clr_i = 1'b0;
    bad_a = '0; bad_b = '0; bad_a_en = 1'b0; bad_b_en = 1'b0; pat_en = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in IDLE; the next posedge is the first normal cycle (cycle 0).
  task automatic reset_dut();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic bit m_err(logic [33:0] a);
    return a[4] ^ a[7];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    ifu_req_valid_i = 1'b1;
    lsu_req_valid_i = 1'b1;
    @(negedge clk);
    total++;
    if ({ifu_req_ready_o, lsu_req_ready_o} !== 2'b00) begin
      bad++; $display("FAIL reset_ready: got %b want 00", {ifu_req_ready_o, lsu_req_ready_o});
    end
    total++;
    if ({ifu_rsp_valid_o, ifu_rsp_err_o, lsu_rsp_valid_o, lsu_rsp_err_o, fault_valid_o} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000",
                      {ifu_rsp_valid_o, ifu_rsp_err_o, lsu_rsp_valid_o, lsu_rsp_err_o, fault_valid_o});
    end
    total++;
    if (pmp_req_addr_o !== 34'h0 || pmp_req_type_o !== PMP_ACC_READ ||
        pmp_req_debug_region_o !== 1'b0 || pmp_priv_lvl_o !== PRIV_LVL_M || fault_addr_o !== 34'h0) begin
      bad++; $display("FAIL reset_pmp: got addr=%h type=%0d dbg=%b priv=%0d faddr=%h want 0/READ/0/M/0",
                      pmp_req_addr_o, pmp_req_type_o, pmp_req_debug_region_o, pmp_priv_lvl_o,
                      fault_addr_o);
    end
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_ifu_basic();
    reset_dut();
    ifu_req_valid_i = 1'b1; ifu_req_addr_i = 34'h0_0000_1003; priv_lvl_i = PRIV_LVL_U;
    @(negedge clk);
    total++;
    if (ifu_req_ready_o !== 1'b1) begin
      bad++; $display("FAIL ifu_ready: got %b want 1", ifu_req_ready_o);
    end
    next_cycle();
    ifu_req_valid_i = 1'b0; priv_lvl_i = PRIV_LVL_M;
    @(negedge clk);
    total++;
    if (pmp_req_addr_o !== 34'h1000 || pmp_req_type_o !== PMP_ACC_EXEC || pmp_priv_lvl_o !== PRIV_LVL_U)
    begin
      bad++; $display("FAIL ifu_check: got addr=%h type=%0d priv=%0d want 1000/EXEC/U",
                      pmp_req_addr_o, pmp_req_type_o, pmp_priv_lvl_o);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({ifu_rsp_valid_o, ifu_rsp_err_o} !== 2'b10) begin
      bad++; $display("FAIL ifu_rsp: got %b want 10", {ifu_rsp_valid_o, ifu_rsp_err_o});
    end
    total++;
    if (pmp_req_addr_o !== 34'h0 || pmp_req_type_o !== PMP_ACC_READ || pmp_priv_lvl_o !== PRIV_LVL_M) begin
      bad++; $display("FAIL ifu_rsp_pmp_idle: got addr=%h type=%0d priv=%0d want 0/READ/M",
                      pmp_req_addr_o, pmp_req_type_o, pmp_priv_lvl_o);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (ifu_rsp_valid_o !== 1'b0) begin
      bad++; $display("FAIL ifu_rsp_single: got %b want 0", ifu_rsp_valid_o);
    end
  endtask

  task automatic test_tie();
    reset_dut();
    ifu_req_valid_i = 1'b1; ifu_req_addr_i = 34'h3000;
    lsu_req_valid_i = 1'b1; lsu_req_addr_i = 34'h100; lsu_req_size_i = 2'd2;
    @(negedge clk);
    total++;
    if ({ifu_req_ready_o, lsu_req_ready_o} !== 2'b01) begin
      bad++; $display("FAIL tie_first: got ifu/lsu ready=%b want 01", {ifu_req_ready_o, lsu_req_ready_o});
    end
    next_cycle();
    lsu_req_valid_i = 1'b0;
    @(negedge clk);
    total++;
    if (ifu_req_ready_o !== 1'b0) begin
      bad++; $display("FAIL tie_no_accept_in_chk: got %b want 0", ifu_req_ready_o);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({lsu_rsp_valid_o, ifu_req_ready_o} !== 2'b11) begin
      bad++; $display("FAIL tie_rsp_accept: got lsu_rsp/ifu_ready=%b want 11",
                      {lsu_rsp_valid_o, ifu_req_ready_o});
    end
    next_cycle();
    ifu_req_valid_i = 1'b0;
    @(negedge clk);
    total++;
    if (pmp_req_addr_o !== 34'h3000 || pmp_req_type_o !== PMP_ACC_EXEC) begin
      bad++; $display("FAIL tie_ifu_check: got addr=%h type=%0d want 3000/EXEC",
                      pmp_req_addr_o, pmp_req_type_o);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({ifu_rsp_valid_o, lsu_rsp_valid_o} !== 2'b10) begin
      bad++; $display("FAIL tie_ifu_rsp: got ifu/lsu rsp=%b want 10", {ifu_rsp_valid_o, lsu_rsp_valid_o});
    end
  endtask

  task automatic test_split();
    reset_dut();
    bad_a = 34'h2004; bad_a_en = 1'b1;
    lsu_req_valid_i = 1'b1; lsu_req_addr_i = 34'h2003; lsu_req_we_i = 1'b1; lsu_req_size_i = 2'd1;
    next_cycle();
    lsu_req_valid_i = 1'b0;
    @(negedge clk);
    total++;
    if (pmp_req_addr_o !== 34'h2003 || pmp_req_type_o !== PMP_ACC_WRITE || lsu_rsp_valid_o !== 1'b0) begin
      bad++; $display("FAIL split_lo: got addr=%h type=%0d rsp=%b want 2003/WRITE/0",
                      pmp_req_addr_o, pmp_req_type_o, lsu_rsp_valid_o);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (pmp_req_addr_o !== 34'h2004 || pmp_req_type_o !== PMP_ACC_WRITE || lsu_rsp_valid_o !== 1'b0) begin
      bad++; $display("FAIL split_hi: got addr=%h type=%0d rsp=%b want 2004/WRITE/0",
                      pmp_req_addr_o, pmp_req_type_o, lsu_rsp_valid_o);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({lsu_rsp_valid_o, lsu_rsp_err_o} !== 2'b11) begin
      bad++; $display("FAIL split_rsp: got %b want 11", {lsu_rsp_valid_o, lsu_rsp_err_o});
    end
    bad_a_en = 1'b0;
  endtask

  task automatic test_wrap();
    reset_dut();
    bad_a = 34'h3_FFFF_FFFE; bad_a_en = 1'b1;
    lsu_req_valid_i = 1'b1; lsu_req_addr_i = 34'h3_FFFF_FFFE; lsu_req_we_i = 1'b0;
    lsu_req_size_i = 2'd2; lsu_req_debug_region_i = 1'b1;
    next_cycle();
    lsu_req_valid_i = 1'b0;
    @(negedge clk);
    total++;
    if (pmp_req_addr_o !== 34'h3_FFFF_FFFE || pmp_req_type_o !== PMP_ACC_READ) begin
      bad++; $display("FAIL wrap_lo: got addr=%h type=%0d want 3fffffffe/READ",
                      pmp_req_addr_o, pmp_req_type_o);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (pmp_req_addr_o !== 34'h0 || pmp_req_debug_region_o !== 1'b1 || lsu_rsp_valid_o !== 1'b0) begin
      bad++; $display("FAIL wrap_hi: got addr=%h dbg=%b rsp=%b want 0/1/0",
                      pmp_req_addr_o, pmp_req_debug_region_o, lsu_rsp_valid_o);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if ({lsu_rsp_valid_o, lsu_rsp_err_o} !== 2'b11) begin
      bad++; $display("FAIL wrap_rsp: got %b want 11", {lsu_rsp_valid_o, lsu_rsp_err_o});
    end
    bad_a_en = 1'b0;
  endtask

  task automatic test_midreset();
    reset_dut();
    lsu_req_valid_i = 1'b1; lsu_req_addr_i = 34'h2003; lsu_req_we_i = 1'b1; lsu_req_size_i = 2'd1;
    next_cycle();
    lsu_req_valid_i = 1'b0;
    next_cycle();
    @(negedge clk);
    total++;
    if (pmp_req_addr_o !== 34'h2004) begin
      bad++; $display("FAIL midrst_in_hi: got addr=%h want 2004", pmp_req_addr_o);
    end
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({lsu_rsp_valid_o, ifu_rsp_valid_o} !== 2'b00 || pmp_req_addr_o !== 34'h0 ||
          pmp_req_type_o !== PMP_ACC_READ || pmp_req_debug_region_o !== 1'b0 ||
          pmp_priv_lvl_o !== PRIV_LVL_M) begin
        bad++; $display("FAIL midrst_quiet: got rsp=%b addr=%h type=%0d dbg=%b priv=%0d want 00/0/READ/0/M",
                        {lsu_rsp_valid_o, ifu_rsp_valid_o}, pmp_req_addr_o, pmp_req_type_o,
                        pmp_req_debug_region_o, pmp_priv_lvl_o);
      end
      next_cycle();
    end
    // A tie now exposes last_grant: LSU wins only if it was restored to IFU.
    ifu_req_valid_i = 1'b1; lsu_req_valid_i = 1'b1;
    @(negedge clk);
    total++;
    if ({ifu_req_ready_o, lsu_req_ready_o} !== 2'b01) begin
      bad++; $display("FAIL midrst_last_grant: got ifu/lsu ready=%b want 01",
                      {ifu_req_ready_o, lsu_req_ready_o});
    end
    idle_inputs();
  endtask

  task automatic test_fault_capture();
    logic        exp_v;
    logic [33:0] exp_a;
`ifdef CV32E41S_PMP_FAULT_CAPTURE_EN
    exp_v = 1'b1; exp_a = 34'h4000;
`else
    exp_v = 1'b0; exp_a = 34'h0;
`endif
    reset_dut();
    bad_a = 34'h4000; bad_a_en = 1'b1; bad_b = 34'h5000; bad_b_en = 1'b1;
    ifu_req_valid_i = 1'b1; ifu_req_addr_i = 34'h4000;
    next_cycle();
    ifu_req_valid_i = 1'b0;
    next_cycle();
    ifu_req_valid_i = 1'b1; ifu_req_addr_i = 34'h5000;
    @(negedge clk);
    total++;
    if ({ifu_rsp_valid_o, ifu_rsp_err_o} !== 2'b11) begin
      bad++; $display("FAIL fault_rsp1: got %b want 11", {ifu_rsp_valid_o, ifu_rsp_err_o});
    end
    next_cycle();
    ifu_req_valid_i = 1'b0;
    next_cycle();
    @(negedge clk);
    total++;
    if ({ifu_rsp_valid_o, ifu_rsp_err_o} !== 2'b11) begin
      bad++; $display("FAIL fault_rsp2: got %b want 11", {ifu_rsp_valid_o, ifu_rsp_err_o});
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      total++;
      if (fault_valid_o !== exp_v || fault_addr_o !== exp_a) begin
        bad++; $display("FAIL fault_sticky: got v=%b addr=%h want v=%b addr=%h",
                        fault_valid_o, fault_addr_o, exp_v, exp_a);
      end
    end
    next_cycle();
    fault_clr_i = 1'b1;
    next_cycle();
    fault_clr_i = 1'b0;
    @(negedge clk);
    total++;
    if (fault_valid_o !== 1'b0 || fault_addr_o !== 34'h0) begin
      bad++; $display("FAIL fault_clear: got v=%b addr=%h want v=0 addr=0", fault_valid_o, fault_addr_o);
    end
    bad_a_en = 1'b0; bad_b_en = 1'b0;
  endtask

  task automatic new_ifu();
    ifu_req_addr_i = {2'($urandom_range(0, 3)), 32'($urandom)};
    if ($urandom_range(0, 7) == 0) ifu_req_addr_i[33:2] = '1;
    ifu_req_debug_region_i = 1'($urandom_range(0, 1));
  endtask

  task automatic new_lsu();
    lsu_req_addr_i = {2'($urandom_range(0, 3)), 32'($urandom)};
    if ($urandom_range(0, 7) == 0) lsu_req_addr_i[33:2] = '1;
    lsu_req_we_i = 1'($urandom_range(0, 1));
    lsu_req_size_i = 2'($urandom_range(0, 3));
    lsu_req_debug_region_i = 1'($urandom_range(0, 1));
  endtask

  task automatic test_random();
    logic [33:0] exp_addr[int];
    pmp_req_e    exp_type[int];
    privlvl_t    exp_priv[int];
    logic        exp_dbg[int];
    int          next_acc;
    int          pend_cyc;
    bit          pend_lsu, pend_err, last_lsu;
    reset_dut();
    pat_en = 1'b1;
    next_acc = 0; pend_cyc = -1; pend_lsu = 1'b0; pend_err = 1'b0; last_lsu = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit          can, win_lsu, any, acc_i, acc_l, split, e_iv, e_lv;
      int          nb;
      logic [33:0] lo, hi;
      @(negedge clk);
      can     = (cyc >= next_acc);
      any     = ifu_req_valid_i || lsu_req_valid_i;
      win_lsu = (ifu_req_valid_i && lsu_req_valid_i) ? !last_lsu : lsu_req_valid_i;
      acc_l   = can && any && win_lsu;
      acc_i   = can && any && !win_lsu;
      total++;
      if ({ifu_req_ready_o, lsu_req_ready_o} !== {acc_i, acc_l}) begin
        bad++; $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc,
                        {ifu_req_ready_o, lsu_req_ready_o}, {acc_i, acc_l});
      end
      e_iv = (pend_cyc == cyc) && !pend_lsu;
      e_lv = (pend_cyc == cyc) && pend_lsu;
      total++;
      if ({ifu_rsp_valid_o, ifu_rsp_err_o, lsu_rsp_valid_o, lsu_rsp_err_o} !==
          {e_iv, e_iv && pend_err, e_lv, e_lv && pend_err}) begin
        bad++; $display("FAIL rnd_rsp cyc%0d: got %b want %b", cyc,
                        {ifu_rsp_valid_o, ifu_rsp_err_o, lsu_rsp_valid_o, lsu_rsp_err_o},
                        {e_iv, e_iv && pend_err, e_lv, e_lv && pend_err});
      end
      total++;
      if (exp_addr.exists(cyc)) begin
        if (pmp_req_addr_o !== exp_addr[cyc] || pmp_req_type_o !== exp_type[cyc] ||
            pmp_priv_lvl_o !== exp_priv[cyc] || pmp_req_debug_region_o !== exp_dbg[cyc]) begin
          bad++; $display("FAIL rnd_check cyc%0d: got %h/%0d/%0d/%b want %h/%0d/%0d/%b", cyc,
                          pmp_req_addr_o, pmp_req_type_o, pmp_priv_lvl_o, pmp_req_debug_region_o,
                          exp_addr[cyc], exp_type[cyc], exp_priv[cyc], exp_dbg[cyc]);
        end
        exp_addr.delete(cyc);
      end else if (pmp_req_addr_o !== 34'h0 || pmp_req_type_o !== PMP_ACC_READ ||
                   pmp_priv_lvl_o !== PRIV_LVL_M || pmp_req_debug_region_o !== 1'b0) begin
        bad++; $display("FAIL rnd_idle_pmp cyc%0d: got %h/%0d/%0d/%b want 0/READ/M/0", cyc,
                        pmp_req_addr_o, pmp_req_type_o, pmp_priv_lvl_o, pmp_req_debug_region_o);
      end
      if (acc_i || acc_l) begin
        lo    = acc_l ? lsu_req_addr_i : {ifu_req_addr_i[33:2], 2'b00};
        nb    = (lsu_req_size_i == 2'd0) ? 1 : (lsu_req_size_i == 2'd1) ? 2 : 4;
        split = acc_l && ((int'(lo[1:0]) + nb) > 4);
        hi    = {lo[33:2], 2'b00} + 34'd4;
        exp_addr[cyc + 1] = lo;
        exp_type[cyc + 1] = acc_i ? PMP_ACC_EXEC : (lsu_req_we_i ? PMP_ACC_WRITE : PMP_ACC_READ);
        exp_priv[cyc + 1] = priv_lvl_i;
        exp_dbg[cyc + 1]  = acc_l ? lsu_req_debug_region_i : ifu_req_debug_region_i;
        if (split) begin
          exp_addr[cyc + 2] = hi;
          exp_type[cyc + 2] = exp_type[cyc + 1];
          exp_priv[cyc + 2] = exp_priv[cyc + 1];
          exp_dbg[cyc + 2]  = exp_dbg[cyc + 1];
        end
        pend_cyc = cyc + (split ? 3 : 2);
        pend_err = m_err(lo) || (split && m_err(hi));
        pend_lsu = acc_l;
        next_acc = pend_cyc;
        last_lsu = acc_l;
      end
      next_cycle();
      priv_lvl_i = privlvl_t'(2'($urandom_range(0, 3)));
      if (acc_i || !ifu_req_valid_i) begin
        ifu_req_valid_i = 1'($urandom_range(0, 1));
        if (ifu_req_valid_i) new_ifu();
      end
      if (acc_l || !lsu_req_valid_i) begin
        lsu_req_valid_i = 1'($urandom_range(0, 1));
        if (lsu_req_valid_i) new_lsu();
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_ifu_basic();
    test_tie();
    test_split();
    test_wrap();
    test_midreset();
    test_fault_capture();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e41s_pmp_check_sched.md
Name: cv32e41s_pmp_check_sched

Overview:
- Shares one combinational PMP checker between the instruction-fetch (IFU) and load/store (LSU) requesters.
- Arbitrates round-robin, latches the winning request and drives the checker from registers.
- Sequences a second check for LSU accesses that cross a word boundary.
- Returns one registered error response per accepted request; sits between the IF/LSU stages and the single PMP checker instance.

Parameters:
- PMP_NUM_REGIONS, 0, number of implemented regions; 0 makes every response use the no-match default path, but the sequencing is unchanged.

Ports:
clk  in  1  core clock
rst_n  in  1  reset, synchronous, active low
priv_lvl_i  in  privlvl_t  current privilege level, sampled at accept
ifu_req_valid_i  in  1  fetch check request
ifu_req_ready_o  out  1  fetch request accepted when valid&&ready
ifu_req_addr_i  in  34  fetch address; bits [1:0] ignored, forced 0
ifu_req_debug_region_i  in  1  fetch targets debug region in debug mode
lsu_req_valid_i  in  1  data check request
lsu_req_ready_o  out  1  data request accepted when valid&&ready
lsu_req_addr_i  in  34  data byte address
lsu_req_we_i  in  1  1=write, 0=read
lsu_req_size_i  in  2  0=byte, 1=half, 2=word; 3 is illegal and treated as word
lsu_req_debug_region_i  in  1  data targets debug region
pmp_req_addr_o  out  34  to checker
pmp_req_type_o  out  pmp_req_e  to checker
pmp_req_debug_region_o  out  1  to checker
pmp_priv_lvl_o  out  privlvl_t  to checker
pmp_req_err_i  in  1  checker result (combinational from pmp_req_*_o)
ifu_rsp_valid_o  out  1  one-cycle response pulse
ifu_rsp_err_o  out  1  access fault; valid only with ifu_rsp_valid_o
lsu_rsp_valid_o  out  1  one-cycle response pulse
lsu_rsp_err_o  out  1  access fault; valid only with lsu_rsp_valid_o
fault_valid_o  out  1  sticky first-fault flag (optional feature)
fault_addr_o  out  34  first faulting check address (optional feature)
fault_clr_i  in  1  clears fault capture

Behaviour:
- FSM states: IDLE, CHK_LO, CHK_HI, RSP. Reset state is IDLE.
- Reset values of every output:
  - all ready/valid/err outputs 0;
  - pmp_req_addr_o 0, pmp_req_type_o PMP_ACC_READ, pmp_req_debug_region_o 0, pmp_priv_lvl_o PRIV_LVL_M;
  - fault_valid_o 0, fault_addr_o 0.
- Ready: {ifu,lsu}_req_ready_o are asserted only in IDLE and RSP, and only toward the arbitration winner. No accept occurs in CHK_LO or CHK_HI.
- Arbitration: last_grant register, reset value IFU.
  - Only one requester valid: that requester is granted.
  - Both valid: grant goes to the requester not in last_grant (so LSU wins the first tie after reset).
  - last_grant updates on accept.
- Accept cycle: latch addr, type, size, debug_region, priv_lvl_i and the requester id; go to CHK_LO.
  - Type: IFU=PMP_ACC_EXEC; LSU = we ? PMP_ACC_WRITE : PMP_ACC_READ.
- CHK_LO: drive the checker from the latched request (IFU address with [1:0]=0) and register err_lo.
  - Go to CHK_HI if split, else to RSP.
  - Split is LSU only, when addr[1:0] + (1<<size) > 4.
- CHK_HI: drive address {addr[33:2]+1, 2'b00}, wrapping modulo 2^34 (addr[33:2] all ones gives 0), and register err_hi.
  - The hi check is always performed, even if err_lo=1, so latency does not depend on the lo result.
- RSP: pulse rsp_valid for the latched requester for exactly one cycle, with err = err_lo | err_hi.
  - A new accept may occur in the same cycle; next state is then CHK_LO, otherwise IDLE.
- Latency from accept to rsp_valid: 2 cycles unsplit, 3 cycles split. Peak throughput is one request per 2 cycles.
- pmp_req_*_o are driven only in CHK_LO/CHK_HI and return to their reset values in IDLE/RSP.
- Requests are not retracted: a requester holds valid and payload until accepted.
- Synchronous reset mid-operation: the in-flight request is dropped with no response; last_grant returns to IFU.

Optional Feature:
- Macro: CV32E41S_PMP_FAULT_CAPTURE_EN.
- Defined:
  - On the first check (lo or hi) with pmp_req_err_i=1 while fault_valid_o=0, capture that check's pmp_req_addr_o into fault_addr_o and set fault_valid_o on the next edge.
  - Later faults do not overwrite the capture.
  - fault_clr_i clears fault_valid_o and fault_addr_o; clear takes precedence over a capture in the same cycle.
- Undefined: fault_valid_o and fault_addr_o are tied 0, fault_clr_i is unused; ports remain present.

Decomposition:
- Additions to cv32e41s_pkg:
  - pmp_sched_state_e {IDLE, CHK_LO, CHK_HI, RSP};
  - pmp_requester_e {PMP_RQ_IFU, PMP_RQ_LSU};
  - struct pmp_sched_req_t {addr, type, size, debug_region, priv_lvl, requester}.
- The existing pmp_req_e and privlvl_t types are reused.
- One sub-module: cv32e41s_pmp_rr_arb2, a 2-input round-robin arbiter holding last_grant, with grant outputs and an update-on-accept input.

Test Plan:
- IFU only, addr 0x0_0000_1003, checker err=0 -> accept in cycle 0; cycle 1 pmp_req_addr_o=0x1000 with type EXEC; cycle 2 ifu_rsp_valid_o=1, err=0.
- Both valid in the same cycle right after reset -> LSU granted first; IFU granted on the RSP-cycle accept; responses arrive 2 cycles apart.
- LSU write, addr 0x2003, size=1 (split) -> checks at 0x2003 then 0x2004 (type WRITE); checker err only on 0x2004 -> lsu_rsp_valid_o at cycle 3 with err=1.
- LSU read, addr 0x3_FFFF_FFFE, size=2 -> hi check address 0x0 (wrap); err_lo=1 -> hi check still issued; err=1 at cycle 3.
- Assert rst_n=0 during CHK_HI -> next cycle IDLE, no rsp_valid pulses, all outputs at reset values.
- With CV32E41S_PMP_FAULT_CAPTURE_EN: two faulting requests at 0x4000 then 0x5000 -> fault_addr_o=0x4000 and sticky; fault_clr_i pulse -> fault_valid_o=0, fault_addr_o=0.
